// File: rtl/squeeze_output_packer.sv
// Packs 12-bit squeeze results eight at a time into 96-bit words and queues them
// in a first-word-fall-through FIFO, with back-pressure, layer tracking and error flags.
module squeeze_output_packer #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int BUSY_THRESH = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [23:0]       total_samples_i,
    input  logic [11:0]       output_data_i,
    input  logic              output_flag_i,
    output logic              output_fifo_busy_o,
    output logic [95:0]       rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_en_i,
    output logic [ADDR_W:0]   fifo_data_count_o,
    output logic              layer_done_o,
    output logic [1:0]        err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_W = (ADDR_W+1)'(BUSY_THRESH);

    state_t            state_reg, state_next;
    logic [95:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next, free_next;
    logic [2:0]        lane_reg;
    logic [23:0]       sample_cnt_reg, total_reg;
    logic [95:0]       pack_reg, pack_merged, word_reg, rd_data_reg, head_next;
    logic              push_pending_reg, push_last_reg;
    logic              rd_valid_reg, busy_reg, busy_next, layer_done_reg;
    logic [1:0]        err_reg;
    logic              sample_in, last_sample, word_done, pop, push_accept, push_drop;

    // Current pack register with the incoming sample dropped into its lane.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign pack_merged[95-12*gi -: 12] = (lane_reg == 3'(gi)) ? output_data_i
                                                                       : pack_reg[95-12*gi -: 12];
        end
    endgenerate

    always_comb begin
        sample_in   = output_flag_i && !start_i && (state_reg == RUN);
        last_sample = (sample_cnt_reg == total_reg);
        word_done   = (lane_reg == 3'd7) || last_sample;
        pop         = rd_en_i && rd_valid_reg;
        push_accept = push_pending_reg && ((count_reg != DEPTH_W) || pop);
        push_drop   = push_pending_reg && !push_accept;
    end

    always_comb begin
        state_next = state_reg;
        if (start_i)
            state_next = RUN;
        else if (sample_in && last_sample)
            state_next = DONE;
    end

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        if (start_i) begin
            count_next  = '0;
            rd_ptr_next = '0;
        end else begin
            if (pop)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push_accept, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
        // A word written this edge is not yet in mem, so forward it when it becomes the head.
        head_next = (push_accept && (rd_ptr_next == wr_ptr_reg)) ? word_reg : mem[rd_ptr_next];
        free_next = DEPTH_W - count_next;
        busy_next = (state_next != RUN) || (free_next <= THRESH_W);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (push_accept && !start_i)
            mem[wr_ptr_reg] <= word_reg;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            total_reg        <= '0;
            sample_cnt_reg   <= '0;
            lane_reg         <= '0;
            pack_reg         <= '0;
            word_reg         <= '0;
            push_pending_reg <= 1'b0;
            push_last_reg    <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            rd_valid_reg     <= 1'b0;
            rd_data_reg      <= '0;
            busy_reg         <= 1'b0;
            layer_done_reg   <= 1'b0;
            err_reg          <= '0;
        end else if (start_i) begin
            total_reg        <= total_samples_i;
            sample_cnt_reg   <= '0;
            lane_reg         <= '0;
            pack_reg         <= '0;
            push_pending_reg <= 1'b0;
            push_last_reg    <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            rd_valid_reg     <= 1'b0;
            busy_reg         <= busy_next;
            layer_done_reg   <= 1'b0;
            err_reg          <= '0;
        end else begin
            layer_done_reg   <= push_pending_reg && push_last_reg;
            push_pending_reg <= 1'b0;
            if (sample_in) begin
                sample_cnt_reg <= sample_cnt_reg + 24'd1;
                if (word_done) begin
                    word_reg         <= pack_merged;
                    push_pending_reg <= 1'b1;
                    push_last_reg    <= last_sample;
                    pack_reg         <= '0;
                    lane_reg         <= '0;
                end else begin
                    pack_reg <= pack_merged;
                    lane_reg <= lane_reg + 3'd1;
                end
            end else if (output_flag_i) begin
                err_reg[1] <= 1'b1;
            end
            if (push_drop)
                err_reg[0] <= 1'b1;
            if (push_accept)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rd_valid_reg <= (count_next != '0);
            if (count_next != '0)
                rd_data_reg <= head_next;
            busy_reg     <= busy_next;
        end
    end

    assign output_fifo_busy_o = busy_reg;
    assign rd_data_o          = rd_data_reg;
    assign rd_valid_o         = rd_valid_reg;
    assign fifo_data_count_o  = count_reg;
    assign layer_done_o       = layer_done_reg;
    assign err_o              = err_reg;

endmodule
